cntr_snapshot_reporter: RTL and testbench

- Sits directly downstream of the N-bit saturating counter and consumes its count output every cycle.
- Detects three events on the count: threshold crossing, saturation, and an explicit software sample request.
- Each event produces a tagged snapshot pushed into a 2-entry report buffer, drained over a valid/ready handshake.
- Optionally issues a clear pulse back to the counter once a saturation report has been consumed.

---
 rtl/cntr_snapshot_reporter_pkg.sv | 15 +
 rtl/cntr_snapshot_reporter_fifo2.sv | 76 +++++++
 rtl/cntr_snapshot_reporter.sv | 144 ++++++++++++++
 tb/tb_cntr_snapshot_reporter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_snapshot_reporter_pkg.sv
// Shared definitions for the counter snapshot reporter: report tags and
// controller state encodings.
package cntr_snapshot_reporter_pkg;

  localparam logic [1:0] TAG_REQ = 2'b00;
  localparam logic [1:0] TAG_THR = 2'b01;
  localparam logic [1:0] TAG_SAT = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CLR       = 2'd1,
    ST_WAIT_ZERO = 2'd2
  } state_e;

endpackage

// File: rtl/cntr_snapshot_reporter_fifo2.sv
// rpt_fifo2: two-entry FIFO with a registered head. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; otherwise it
// is discarded and the caller decides how to flag the loss.
module rpt_fifo2 #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;

  // Storage and occupancy registers; mem0 is always the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next occupancy and contents for every push/pop combination.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    cnt_d   = cnt_q;
    pop_ok  = pop_i & (cnt_q != 2'd0);
    push_ok = push_i & ((cnt_q != 2'd2) | pop_ok);
    unique case ({push_ok, pop_ok})
      2'b11: begin
        if (cnt_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = data_i;
        end else begin
          mem0_d = data_i;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          mem0_d = mem1_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) begin
          mem0_d = data_i;
        end else begin
          mem1_d = data_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem0_q;

endmodule

// File: rtl/cntr_snapshot_reporter.sv
// cntr_snapshot_reporter: watches the saturating counter, turns threshold
// crossings, saturation and software sample requests into tagged snapshots
// and queues them in a two-entry report buffer.
// Build option CNTR_SNAPSHOT_AUTO_CLR_EN: after a saturation report is
// consumed, pulse cntr_clr once and hold off detection until the count is 0.
// Without it cntr_clr is tied low and the controller stays in RUN.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   ST_RUN       | event detection active
//   ST_CLR       | one-cycle clear pulse to the counter
//   ST_WAIT_ZERO | detection suppressed until cntr_in == 0
module cntr_snapshot_reporter
  import cntr_snapshot_reporter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_COUNT = 2**N - 1,
  parameter int THRESH    = 2**(N-1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cntr_in,
  input  logic         sample_req,
  input  logic         err_clr,
  output logic         rpt_valid,
  input  logic         rpt_ready,
  output logic [N-1:0] rpt_data,
  output logic [1:0]   rpt_tag,
  output logic         drop_err,
  output logic         cntr_clr
);

  localparam logic [N-1:0] THR_N = N'(THRESH);
  localparam logic [N-1:0] MAX_N = N'(MAX_COUNT);

  state_e         state_q, state_d;
  logic [N-1:0]   prev_cnt_q;
  logic           drop_err_q, drop_err_d;
  logic           det_en;
  logic           thr_evt;
  logic           sat_evt;
  logic           push;
  logic [1:0]     push_tag;
  logic           pop;
  logic           full;
  logic           empty;
  logic           drop;
  logic [N+1:0]   head;

  rpt_fifo2 #(.W(N + 2)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({push_tag, cntr_in}),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign rpt_valid           = ~empty;
  assign {rpt_tag, rpt_data} = head;
  assign pop                 = rpt_valid & rpt_ready;

  // Previous count and sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_cnt_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      prev_cnt_q <= cntr_in;
      drop_err_q <= drop_err_d;
    end
  end

  // Event detection with saturation > threshold > request priority; only
  // the winning event is pushed, the losers vanish without a drop.
  always_comb begin
    thr_evt  = (prev_cnt_q < THR_N) && (cntr_in >= THR_N);
    sat_evt  = (cntr_in == MAX_N) && (prev_cnt_q != MAX_N);
    push     = det_en & (sat_evt | thr_evt | sample_req);
    push_tag = TAG_REQ;
    if (sat_evt) begin
      push_tag = TAG_SAT;
    end else if (thr_evt) begin
      push_tag = TAG_THR;
    end
    drop       = push & full & ~pop;
    drop_err_d = drop_err_q;
    if (drop) begin
      drop_err_d = 1'b1;
    end else if (err_clr) begin
      drop_err_d = 1'b0;
    end
  end

  assign drop_err = drop_err_q;

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state: leaves RUN only when a saturation report is taken.
  always_comb begin
    state_d = state_q;
`ifdef CNTR_SNAPSHOT_AUTO_CLR_EN
    unique case (state_q)
      ST_RUN: begin
        if (pop && (rpt_tag == TAG_SAT)) begin
          state_d = ST_CLR;
        end
      end
      ST_CLR: begin
        state_d = ST_WAIT_ZERO;
      end
      ST_WAIT_ZERO: begin
        if (cntr_in == '0) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
`else
    state_d = ST_RUN;
`endif
  end

  // Controller outputs: detection enable and the counter clear pulse.
  always_comb begin
    det_en   = (state_q == ST_RUN);
    cntr_clr = 1'b0;
`ifdef CNTR_SNAPSHOT_AUTO_CLR_EN
    cntr_clr = (state_q == ST_CLR);
`endif
  end

endmodule

// File: tb/tb_cntr_snapshot_reporter.sv
// Bench for cntr_snapshot_reporter (N=4 defaults): directed scenarios plus
// random traffic against a queue-based reference model.
module tb_cntr_snapshot_reporter;

  localparam int THR  = 8;
  localparam int MAXC = 15;
`ifdef CNTR_SNAPSHOT_AUTO_CLR_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cntr_in = '0;
  logic       sample_req = 1'b0;
  logic       err_clr = 1'b0;
  logic       rpt_valid;
  logic       rpt_ready = 1'b0;
  logic [3:0] rpt_data;
  logic [1:0] rpt_tag;
  logic       drop_err;
  logic       cntr_clr;

  int n_vec = 0;
  int n_err = 0;

  // reference model: queue of {tag,data}, sticky drop, last count, mode
  // (0 detect, 1 clear pulse, 2 waiting for zero)
  logic [5:0] mq[$];
  bit         m_drop;
  int         m_prev;
  int         m_mode;

  cntr_snapshot_reporter dut (
    .clk        (clk),
    .reset      (reset),
    .cntr_in    (cntr_in),
    .sample_req (sample_req),
    .err_clr    (err_clr),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_data   (rpt_data),
    .rpt_tag    (rpt_tag),
    .drop_err   (drop_err),
    .cntr_clr   (cntr_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("rpt_valid", rpt_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("rpt_data", rpt_data, mq[0][3:0]);
      check_eq("rpt_tag", rpt_tag, mq[0][5:4]);
    end
    check_eq("drop_err", drop_err, m_drop);
    check_eq("cntr_clr", cntr_clr, m_mode == 1);
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input int c, input bit rq, input bit rd, input bit ec);
    bit         push;
    bit         popped_sat;
    logic [5:0] ent;
    int         nm;
    cntr_in    = 4'(c);
    sample_req = rq;
    rpt_ready  = rd;
    err_clr    = ec;
    push       = 1'b0;
    popped_sat = 1'b0;
    ent        = '0;
    nm         = m_mode;
    if (m_mode == 0) begin
      if (c == MAXC && m_prev != MAXC) begin
        push = 1'b1; ent = {2'b10, 4'(c)};
      end else if (m_prev < THR && c >= THR) begin
        push = 1'b1; ent = {2'b01, 4'(c)};
      end else if (rq) begin
        push = 1'b1; ent = {2'b00, 4'(c)};
      end
    end
    if (rd && mq.size() > 0) begin
      popped_sat = (mq[0][5:4] == 2'b10);
      mq.delete(0);
    end
    if (push && mq.size() >= 2) begin
      m_drop = 1'b1;
    end else begin
      if (push) mq.push_back(ent);
      if (ec) m_drop = 1'b0;
    end
    if (FEAT) begin
      case (m_mode)
        0: if (popped_sat) nm = 1;
        1: nm = 2;
        2: if (c == 0) nm = 0;
        default: nm = 0;
      endcase
    end
    m_mode = nm;
    m_prev = c;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Assert reset away from the clock edge and check it acts immediately.
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    mq.delete();
    m_drop = 1'b0;
    m_prev = 0;
    m_mode = 0;
    check_eq("rst_valid", rpt_valid, 0);
    check_eq("rst_data", rpt_data, 0);
    check_eq("rst_tag", rpt_tag, 0);
    check_eq("rst_drop", drop_err, 0);
    check_eq("rst_clr", cntr_clr, 0);
    cntr_in = '0; sample_req = 1'b0; rpt_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int c;
    int r;
    do_reset();

    // ramp with consumer always ready
    for (int i = 0; i <= 15; i++) begin
      step(i, 1'b0, 1'b1, 1'b0);
      if (i == 8) begin
        check_eq("ramp_thr_valid", rpt_valid, 1);
        check_eq("ramp_thr_data", rpt_data, 8);
        check_eq("ramp_thr_tag", rpt_tag, 1);
      end
      if (i == 9) check_eq("ramp_thr_gone", rpt_valid, 0);
      if (i == 15) begin
        check_eq("ramp_sat_data", rpt_data, 15);
        check_eq("ramp_sat_tag", rpt_tag, 2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(15, 1'b0, 1'b1, 1'b0);
      check_eq("ramp_hold_no_rpt", rpt_valid, 0);
    end

    // request coinciding with threshold crossing
    do_reset();
    for (int i = 0; i < 8; i++) step(i, 1'b0, 1'b1, 1'b0);
    step(8, 1'b1, 1'b1, 1'b0);
    check_eq("coinc_tag", rpt_tag, 1);
    check_eq("coinc_data", rpt_data, 8);
    step(9, 1'b0, 1'b1, 1'b0);
    check_eq("coinc_single", rpt_valid, 0);
    check_eq("coinc_drop", drop_err, 0);

    // full buffer, drop, drain, clear
    do_reset();
    step(3, 1'b1, 1'b0, 1'b0);
    step(8, 1'b0, 1'b0, 1'b0);
    step(15, 1'b0, 1'b0, 1'b0);
    check_eq("full_drop", drop_err, 1);
    check_eq("full_head_data", rpt_data, 3);
    check_eq("full_head_tag", rpt_tag, 0);
    step(15, 1'b0, 1'b1, 1'b0);
    check_eq("drain_data", rpt_data, 8);
    check_eq("drain_tag", rpt_tag, 1);
    step(15, 1'b0, 1'b1, 1'b0);
    check_eq("drain_empty", rpt_valid, 0);
    step(15, 1'b0, 1'b0, 1'b1);
    check_eq("err_clr", drop_err, 0);

    // auto-clear sequence (only meaningful with the feature)
    do_reset();
    for (int i = 0; i <= 15; i++) step(i, 1'b0, 1'b1, 1'b0);
    step(15, 1'b0, 1'b1, 1'b0);
    step(15, 1'b1, 1'b1, 1'b0);
    step(15, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0);
    check_eq("req_after_zero_tag", rpt_tag, 0);
    check_eq("req_after_zero_valid", rpt_valid, 1);

    // two entries buffered while clearing, then async reset
    do_reset();
    step(15, 1'b0, 1'b0, 1'b0);
    step(15, 1'b1, 1'b0, 1'b0);
    step(15, 1'b1, 1'b1, 1'b0);
    step(15, 1'b1, 1'b0, 1'b0);
    step(15, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i <= 9; i++) begin
      step(i, 1'b0, 1'b1, 1'b0);
      if (i == 8) begin
        check_eq("post_rst_thr_data", rpt_data, 8);
        check_eq("post_rst_thr_tag", rpt_tag, 1);
      end
    end

    // random traffic
    do_reset();
    c = 0;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) c = (c < 15) ? c + 1 : 15;
      else if (r == 6) c = 0;
      else if (r == 7) c = $urandom_range(0, 15);
      step(c, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
